// File: rtl/rf_bank_pkg.sv
// Shared types and helpers for the lockable register-file bank.
package rf_bank_pkg;

  typedef enum logic {IDLE, SWEEP} flush_state_e;

  // Upper bounds for the merge helper; bank entries are zero-extended into these.
  localparam int MAX_WORDS   = 32;
  localparam int MAX_ENTRY_W = 256;

  function automatic logic [MAX_ENTRY_W-1:0] merge_words(
    input logic [MAX_ENTRY_W-1:0] old_val,
    input logic [MAX_ENTRY_W-1:0] new_val,
    input logic [MAX_WORDS-1:0]   word_wen,
    input int                     word_w
  );
    logic [MAX_ENTRY_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (word_wen[i]) mask = mask | (({MAX_ENTRY_W{1'b1}} >> (MAX_ENTRY_W - word_w)) << (i * word_w));
    end
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/rf_bank_lockable_flush.sv
// Flush sequencer: walks every entry once after flush_req, one entry per cycle.
// Requests arriving mid-sweep are dropped; busy is high for exactly DEPTH cycles.
module rf_flush_ctrl
  import rf_bank_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  flush_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_busy = (state_q == SWEEP);
  assign clr_en     = (state_q == SWEEP);
  assign clr_addr   = ptr_q;

endmodule

// File: rtl/rf_bank_lockable.sv
// Register-file bank with sub-word write enables, sticky per-entry locks and a flush sweep.
// Read data is registered (1 cycle) and bypasses this cycle's write/clear.
module rf_bank_lockable
  import rf_bank_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int WORD_W    = 8,
  parameter  int NUM_WORDS = 4,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int ENTRY_W   = NUM_WORDS * WORD_W
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wen,
  input  logic [NUM_WORDS-1:0] word_wen,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [ENTRY_W-1:0]   wr_data,
  input  logic                 lock_en,
  input  logic [ADDR_W-1:0]    lock_addr,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [ENTRY_W-1:0]   rd_data,
  output logic                 rd_valid,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 wr_blocked,
  output logic [DEPTH-1:0]     lock_status
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   lock_q;
  logic               clr_en, clr_hit;
  logic [ADDR_W-1:0]  clr_addr;
  logic               wr_req, wr_locked, wr_ok, wr_rej;
  logic [ENTRY_W-1:0] wr_new, rd_next;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  rf_flush_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_flush (
    .clk        (clk),
    .reset      (reset),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .clr_en     (clr_en),
    .clr_addr   (clr_addr)
  );

  // Write and sweep both see the pre-edge lock bits; a same-cycle lock only protects from the next cycle on.
  always_comb begin
    wr_req    = wen && (|word_wen) && in_range(wr_addr);
    wr_locked = wr_req && lock_q[wr_addr];
    wr_ok     = wr_req && !wr_locked && !flush_busy;
    wr_rej    = wr_req && (wr_locked || flush_busy);
    clr_hit   = clr_en && !lock_q[clr_addr];
    wr_new    = ENTRY_W'(merge_words(MAX_ENTRY_W'(mem[wr_addr]), MAX_ENTRY_W'(wr_data),
                                     MAX_WORDS'(word_wen), WORD_W));
    rd_next   = '0;
    if (in_range(rd_addr)) begin
      rd_next = mem[rd_addr];
      if (clr_hit && clr_addr == rd_addr) rd_next = '0;
      else if (wr_ok && wr_addr == rd_addr) rd_next = wr_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (clr_hit) mem[clr_addr] <= '0;
      if (wr_ok)   mem[wr_addr]  <= wr_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      wr_blocked <= 1'b0;
    end else begin
      if (lock_en && in_range(lock_addr)) lock_q[lock_addr] <= 1'b1;
      if (rd_en) rd_data <= rd_next;
      rd_valid   <= rd_en;
      wr_blocked <= wr_rej;
    end
  end

  assign lock_status = lock_q;

endmodule

// File: tb/tb_rf_bank_lockable.sv
// Randomized and directed checks of rf_bank_lockable against an array-based reference model.
module tb_rf_bank_lockable;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen, lock_en, rd_en, flush_req;
  logic [3:0]  word_wen, wr_addr, lock_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, flush_busy, wr_blocked;
  logic [15:0] lock_status;

  logic        d12_wen, d12_lock_en, d12_rd_en, d12_flush_req;
  logic [3:0]  d12_word_wen, d12_wr_addr, d12_lock_addr, d12_rd_addr;
  logic [31:0] d12_wr_data, d12_rd_data;
  logic        d12_rd_valid, d12_flush_busy, d12_wr_blocked;
  logic [11:0] d12_lock_status;

  always #5 clk = ~clk;

  rf_bank_lockable dut (
    .clk(clk), .reset(reset), .wen(wen), .word_wen(word_wen), .wr_addr(wr_addr),
    .wr_data(wr_data), .lock_en(lock_en), .lock_addr(lock_addr), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .flush_req(flush_req),
    .flush_busy(flush_busy), .wr_blocked(wr_blocked), .lock_status(lock_status)
  );

  rf_bank_lockable #(.DEPTH(12)) dut12 (
    .clk(clk), .reset(reset), .wen(d12_wen), .word_wen(d12_word_wen), .wr_addr(d12_wr_addr),
    .wr_data(d12_wr_data), .lock_en(d12_lock_en), .lock_addr(d12_lock_addr), .rd_en(d12_rd_en),
    .rd_addr(d12_rd_addr), .rd_data(d12_rd_data), .rd_valid(d12_rd_valid), .flush_req(d12_flush_req),
    .flush_busy(d12_flush_busy), .wr_blocked(d12_wr_blocked), .lock_status(d12_lock_status)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain arrays plus a count of sweep cycles still to run.
  logic [31:0] m_mem [DEPTH];
  bit          m_lock [DEPTH];
  int          flush_left;
  logic [31:0] e_rd_data;
  bit          e_rd_valid, e_wr_blocked;

  function automatic logic [15:0] lock_vec();
    logic [15:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_lock[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_lock[i] = 0;
    end
    flush_left   = 0;
    e_rd_data    = '0;
    e_rd_valid   = 0;
    e_wr_blocked = 0;
  endtask

  task automatic model_edge();
    bit busy;
    int k;
    busy = flush_left > 0;
    e_wr_blocked = 0;
    if (wen && word_wen != 4'd0 && int'(wr_addr) < DEPTH) begin
      if (m_lock[wr_addr] || busy) e_wr_blocked = 1;
      else for (int i = 0; i < 4; i++) if (word_wen[i]) m_mem[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
    end
    if (busy) begin
      k = DEPTH - flush_left;
      if (!m_lock[k]) m_mem[k] = '0;
      flush_left--;
    end else if (flush_req) begin
      flush_left = DEPTH;
    end
    if (lock_en) m_lock[lock_addr] = 1;
    e_rd_valid = rd_en;
    if (rd_en) e_rd_data = m_mem[rd_addr];
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, e_rd_valid);
    chk("rd_data", rd_data, e_rd_data);
    chk("wr_blocked", wr_blocked, e_wr_blocked);
    chk("flush_busy", flush_busy, flush_left > 0);
    chk("lock_status", lock_status, lock_vec());
  endtask

  task automatic idle();
    wen = 0; word_wen = '0; wr_addr = '0; wr_data = '0; lock_en = 0; lock_addr = '0;
    rd_en = 0; rd_addr = '0; flush_req = 0;
    d12_wen = 0; d12_word_wen = '0; d12_wr_addr = '0; d12_wr_data = '0; d12_lock_en = 0;
    d12_lock_addr = '0; d12_rd_en = 0; d12_rd_addr = '0; d12_flush_req = 0;
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any clock edge.
  task automatic do_reset();
    #2 reset = 1;
    #1;
    chk("rst_flush_busy", flush_busy, 1'b0);
    chk("rst_lock_status", lock_status, 16'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_wr_blocked", wr_blocked, 1'b0);
    chk("rst_d12_lock_status", d12_lock_status, 12'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic write(input logic [3:0] a, input logic [3:0] ww, input logic [31:0] d);
    idle(); wen = 1; word_wen = ww; wr_addr = a; wr_data = d;
    step();
  endtask

  task automatic read_check(input logic [3:0] a, input logic [31:0] exp, input string tag);
    idle(); rd_en = 1; rd_addr = a;
    step();
    chk(tag, rd_data, exp);
  endtask

  task automatic sweep_len(output int cnt);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!flush_busy) break;
      cnt++;
      idle();
      if (c == 2) begin
        wen = 1; word_wen = 4'hF; wr_addr = 4'd4; wr_data = 32'h12345678;
      end
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    idle();
    reset = 1;
    model_reset();
    #12;
    chk("init_rd_data", rd_data, 32'h0);
    chk("init_flush_busy", flush_busy, 1'b0);
    chk("init_lock_status", lock_status, 16'h0);
    reset = 0;

    write(4'd3, 4'b0101, 32'hAABBCCDD);
    read_check(4'd3, 32'h00BB00DD, "partial_write");
    chk("partial_rd_valid", rd_valid, 1'b1);
    idle(); step();
    chk("rd_valid_drop", rd_valid, 1'b0);

    idle(); wen = 1; word_wen = 4'hF; wr_addr = 4'd5; wr_data = 32'h11223344; rd_en = 1; rd_addr = 4'd5;
    step();
    chk("bypass", rd_data, 32'h11223344);

    idle(); lock_en = 1; lock_addr = 4'd7; step();
    write(4'd7, 4'hF, 32'hDEADBEEF);
    chk("locked_wr_blocked", wr_blocked, 1'b1);
    chk("lock7", lock_status[7], 1'b1);
    read_check(4'd7, 32'h0, "locked_unchanged");
    chk("blocked_pulse_end", wr_blocked, 1'b0);
    idle(); lock_en = 1; lock_addr = 4'd9; wen = 1; word_wen = 4'hF; wr_addr = 4'd9; wr_data = 32'hCAFEF00D;
    step();
    read_check(4'd9, 32'hCAFEF00D, "same_cycle_lock_write");
    write(4'd9, 4'hF, 32'h0);
    chk("lock9_blocks", wr_blocked, 1'b1);

    do_reset();
    for (int a = 0; a < DEPTH; a++) write(4'(a), 4'hF, 32'hFFFFFFFF);
    idle(); lock_en = 1; lock_addr = 4'd2; step();
    idle(); lock_en = 1; lock_addr = 4'd15; step();
    idle(); flush_req = 1; step();
    sweep_len(cnt);
    chk("flush_len", cnt, 16);
    for (int a = 0; a < DEPTH; a++)
      read_check(4'(a), (a == 2 || a == 15) ? 32'hFFFFFFFF : 32'h0, "after_flush");

    write(4'd10, 4'hF, 32'h5A5A5A5A);
    idle(); lock_en = 1; lock_addr = 4'd3; step();
    idle(); rd_en = 1; rd_addr = 4'd2; flush_req = 1; step();
    idle();
    for (int c = 0; c < 5; c++) step();
    do_reset();
    idle(); flush_req = 1; step();
    sweep_len(cnt);
    chk("flush_len_after_reset", cnt, 16);
    for (int a = 0; a < DEPTH; a++) read_check(4'(a), 32'h0, "cleared_by_reset");

    idle(); d12_wen = 1; d12_word_wen = 4'hF; d12_wr_addr = 4'd13; d12_wr_data = 32'hFFFFFFFF;
    d12_lock_en = 1; d12_lock_addr = 4'd13; d12_rd_en = 1; d12_rd_addr = 4'd13;
    step();
    chk("d12_oob_rd_data", d12_rd_data, 32'h0);
    chk("d12_oob_rd_valid", d12_rd_valid, 1'b1);
    chk("d12_oob_wr_blocked", d12_wr_blocked, 1'b0);
    chk("d12_oob_lock", d12_lock_status, 12'h0);
    idle(); d12_wen = 1; d12_word_wen = 4'hF; d12_wr_addr = 4'd11; d12_wr_data = 32'h0BADCAFE;
    d12_rd_en = 1; d12_rd_addr = 4'd11;
    step();
    chk("d12_last_entry", d12_rd_data, 32'h0BADCAFE);

    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        idle();
        wen       = 1'($urandom_range(0, 1));
        word_wen  = 4'($urandom);
        wr_addr   = 4'($urandom);
        wr_data   = $urandom;
        lock_en   = ($urandom_range(0, 24) == 0);
        lock_addr = 4'($urandom);
        rd_en     = 1'($urandom_range(0, 1));
        rd_addr   = 4'($urandom);
        flush_req = (round == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
